// File: rtl/bp_be_mmu_cmd_buffer_pkg.sv
// Shared types for the BE <-> MMU command buffer.
// Defines the MMU command and response formats, their packed widths, the
// per-entry storage record, and the default buffer depth.
package bp_be_mmu_cmd_buffer_pkg;

    localparam int rv64_eaddr_width_gp         = 64;
    localparam int rv64_reg_data_width_gp      = 64;
    localparam int bp_be_mmu_cmd_buffer_els_gp = 4;

    typedef enum logic [3:0] {
        e_op_lb = 4'h0,
        e_op_lh = 4'h1,
        e_op_lw = 4'h2,
        e_op_ld = 4'h3,
        e_op_sb = 4'h8,
        e_op_sh = 4'h9,
        e_op_sw = 4'ha,
        e_op_sd = 4'hb
    } bp_be_mmu_op_e;

    typedef struct packed {
        bp_be_mmu_op_e                     mem_op;
        logic [rv64_eaddr_width_gp-1:0]    vaddr;
        logic [rv64_reg_data_width_gp-1:0] data;
    } bp_be_mmu_cmd_s;

    typedef struct packed {
        logic       load_misaligned;
        logic       store_misaligned;
        logic       load_access_fault;
        logic       store_access_fault;
        logic       load_page_fault;
        logic       store_page_fault;
        logic [1:0] rsvd;
    } bp_be_mmu_exception_s;

    typedef struct packed {
        bp_be_mmu_exception_s              exception;
        logic [rv64_reg_data_width_gp-1:0] data;
    } bp_be_mmu_resp_s;

    localparam int bp_be_mmu_cmd_width_gp  = $bits(bp_be_mmu_cmd_s);
    localparam int bp_be_mmu_resp_width_gp = $bits(bp_be_mmu_resp_s);

    typedef struct packed {
        bp_be_mmu_cmd_s  cmd;
        bp_be_mmu_resp_s resp;
        logic            filled;
    } bp_be_mmu_cmd_buffer_entry_s;

endpackage

// File: rtl/bp_be_mmu_cmd_buffer_ptr.sv
// Wrap-bit circular-buffer pointer.
// Ports: clk_i/reset_i (sync, active-high), inc_i advances by one,
// load_i overwrites with load_val_i (takes priority over inc_i), ptr_o is
// the registered pointer including its wrap bit in the MSB.
module bp_be_mmu_cmd_buffer_ptr #(
    parameter int ptr_width_p = 3
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   inc_i,
    input  logic                   load_i,
    input  logic [ptr_width_p-1:0] load_val_i,
    output logic [ptr_width_p-1:0] ptr_o
);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            ptr_o <= '0;
        end else if (load_i) begin
            ptr_o <= load_val_i;
        end else if (inc_i) begin
            ptr_o <= ptr_o + ptr_width_p'(1);
        end
    end

endmodule

// File: rtl/bp_be_mmu_cmd_buffer.sv
// In-order multi-outstanding buffer between the BE memory pipe and the MMU.
// Ports:
//   cmd_i/cmd_v_i/cmd_ready_o          : commands from the BE (ready = not full)
//   mem_cmd_o/mem_cmd_v_o/mem_cmd_ready_i : issue port to the MMU
//   mem_resp_i/mem_resp_v_i            : in-order MMU responses, never stalled
//   resp_o/resp_v_o/resp_yumi_i        : head response back to the BE
//   flush_i                            : drop queued ops, squash in-flight ones
module bp_be_mmu_cmd_buffer
    import bp_be_mmu_cmd_buffer_pkg::*;
#(
    parameter int els_p         = bp_be_mmu_cmd_buffer_els_gp,
    parameter int eaddr_width_p = rv64_eaddr_width_gp,
    parameter int data_width_p  = rv64_reg_data_width_gp,
    parameter int cmd_width_p   = bp_be_mmu_cmd_width_gp,
    parameter int resp_width_p  = bp_be_mmu_resp_width_gp
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [cmd_width_p-1:0]  cmd_i,
    input  logic                    cmd_v_i,
    output logic                    cmd_ready_o,
    output logic [cmd_width_p-1:0]  mem_cmd_o,
    output logic                    mem_cmd_v_o,
    input  logic                    mem_cmd_ready_i,
    input  logic [resp_width_p-1:0] mem_resp_i,
    input  logic                    mem_resp_v_i,
    output logic [resp_width_p-1:0] resp_o,
    output logic                    resp_v_o,
    input  logic                    resp_yumi_i,
    input  logic                    flush_i
);

    localparam int lg_els_lp    = $clog2(els_p);
    localparam int ptr_width_lp = lg_els_lp + 1;
    localparam int cnt_width_lp = $clog2(els_p + 1);

    if ((els_p < 2) || ((els_p & (els_p - 1)) != 0)) begin : g_bad_els
        $error("els_p must be a power of two >= 2");
    end
    if (cmd_width_p < eaddr_width_p + data_width_p) begin : g_bad_cmd
        $error("cmd_width_p too narrow for address and data");
    end

    logic [ptr_width_lp-1:0] wr_ptr, iss_ptr, fill_ptr, ret_ptr;
    logic [ptr_width_lp-1:0] iss_next;
    logic [ptr_width_lp-1:0] inflight;
    logic [cnt_width_lp-1:0] drop_cnt_r, drop_flush;

    logic [cmd_width_p-1:0]  cmd_mem  [els_p];
    logic [resp_width_p-1:0] resp_mem [els_p];
    logic [els_p-1:0]        filled_r;

    logic full, drop_idle;
    logic cmd_we, iss_inc, resp_we;

    assign drop_idle = (drop_cnt_r == '0);
    assign full      = (wr_ptr[lg_els_lp-1:0] == ret_ptr[lg_els_lp-1:0])
                     & (wr_ptr[lg_els_lp] != ret_ptr[lg_els_lp]);

    assign cmd_ready_o = ~full;
    assign mem_cmd_v_o = (iss_ptr != wr_ptr) & drop_idle;
    assign mem_cmd_o   = cmd_mem[iss_ptr[lg_els_lp-1:0]];
    assign resp_v_o    = filled_r[ret_ptr[lg_els_lp-1:0]];
    assign resp_o      = resp_mem[ret_ptr[lg_els_lp-1:0]];

    // A command accepted in a flush cycle is dropped, so wr does not advance.
    assign cmd_we  = cmd_v_i & cmd_ready_o & ~flush_i;
    assign iss_inc = mem_cmd_v_o & mem_cmd_ready_i;
    assign resp_we = mem_resp_v_i & drop_idle & ~flush_i;

    // Ops issued but not yet answered, counting an issue in this very cycle.
    // A response arriving alongside a flush retires the oldest of those (or
    // one of the already-squashed ones), so it is subtracted either way.
    assign iss_next   = iss_ptr + ptr_width_lp'(iss_inc);
    assign inflight   = iss_next - fill_ptr;
    assign drop_flush = drop_cnt_r + cnt_width_lp'(inflight)
                      - cnt_width_lp'(mem_resp_v_i);

    bp_be_mmu_cmd_buffer_ptr #(.ptr_width_p(ptr_width_lp)) wr_ptr_u (
        .clk_i(clk_i), .reset_i(reset_i), .inc_i(cmd_we),
        .load_i(flush_i), .load_val_i(wr_ptr), .ptr_o(wr_ptr)
    );
    bp_be_mmu_cmd_buffer_ptr #(.ptr_width_p(ptr_width_lp)) iss_ptr_u (
        .clk_i(clk_i), .reset_i(reset_i), .inc_i(iss_inc),
        .load_i(flush_i), .load_val_i(wr_ptr), .ptr_o(iss_ptr)
    );
    bp_be_mmu_cmd_buffer_ptr #(.ptr_width_p(ptr_width_lp)) fill_ptr_u (
        .clk_i(clk_i), .reset_i(reset_i), .inc_i(resp_we),
        .load_i(flush_i), .load_val_i(wr_ptr), .ptr_o(fill_ptr)
    );
    bp_be_mmu_cmd_buffer_ptr #(.ptr_width_p(ptr_width_lp)) ret_ptr_u (
        .clk_i(clk_i), .reset_i(reset_i), .inc_i(resp_yumi_i),
        .load_i(flush_i), .load_val_i(wr_ptr), .ptr_o(ret_ptr)
    );

    // Payload storage carries no reset; validity lives in the pointers and filled_r.
    always_ff @(posedge clk_i) begin
        if (cmd_we) begin
            cmd_mem[wr_ptr[lg_els_lp-1:0]] <= cmd_i;
        end
        if (resp_we) begin
            resp_mem[fill_ptr[lg_els_lp-1:0]] <= mem_resp_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i || flush_i) begin
            filled_r <= '0;
        end else begin
            if (resp_yumi_i) begin
                filled_r[ret_ptr[lg_els_lp-1:0]] <= 1'b0;
            end
            if (resp_we) begin
                filled_r[fill_ptr[lg_els_lp-1:0]] <= 1'b1;
            end
        end
    end

    // Issue is held off while drop_cnt_r is nonzero, which bounds it at els_p.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            drop_cnt_r <= '0;
        end else if (flush_i) begin
            drop_cnt_r <= drop_flush;
        end else if (mem_resp_v_i && !drop_idle) begin
            drop_cnt_r <= drop_cnt_r - cnt_width_lp'(1);
        end
    end

endmodule

// File: tb/tb_bp_be_mmu_cmd_buffer.sv
module tb_bp_be_mmu_cmd_buffer;
    import bp_be_mmu_cmd_buffer_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_v = 1'b0, cmd_ready;
    logic mem_cmd_v, mem_cmd_ready = 1'b0;
    logic mem_resp_v = 1'b0;
    logic resp_v, resp_yumi = 1'b0;
    logic flush = 1'b0;
    bp_be_mmu_cmd_s  cmd_in = '0;
    bp_be_mmu_cmd_s  mem_cmd;
    bp_be_mmu_resp_s mem_resp = '0;
    bp_be_mmu_resp_s resp_out;

    int vectors = 0;
    int miscompares = 0;

    bp_be_mmu_resp_s exp_q[$];
    bp_be_mmu_cmd_s  iss_q[$];
    bp_be_mmu_cmd_s  pend_q[$];

    always #5 clk = ~clk;

    bp_be_mmu_cmd_buffer dut (
        .clk_i(clk), .reset_i(reset),
        .cmd_i(cmd_in), .cmd_v_i(cmd_v), .cmd_ready_o(cmd_ready),
        .mem_cmd_o(mem_cmd), .mem_cmd_v_o(mem_cmd_v), .mem_cmd_ready_i(mem_cmd_ready),
        .mem_resp_i(mem_resp), .mem_resp_v_i(mem_resp_v),
        .resp_o(resp_out), .resp_v_o(resp_v), .resp_yumi_i(resp_yumi),
        .flush_i(flush)
    );

    function automatic bp_be_mmu_cmd_s make_cmd(input int i);
        bp_be_mmu_cmd_s c;
        c.mem_op = e_op_ld;
        c.vaddr  = 64'(i) * 64'd8;
        c.data   = 64'(i) ^ 64'h1234_0000_0000_4321;
        return c;
    endfunction

    // Memory model: response derived from the command it answers.
    function automatic bp_be_mmu_resp_s mem_model(input bp_be_mmu_cmd_s c);
        bp_be_mmu_resp_s r;
        r.exception = bp_be_mmu_exception_s'(c.vaddr[10:3] & 8'h11);
        r.data      = c.vaddr ^ c.data ^ 64'hA5A5_0000_0000_5A5A;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cmd_v = 0; mem_cmd_ready = 0; mem_resp_v = 0; resp_yumi = 0; flush = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            $display("FAIL %s cmd_ready: got %b want 1", tag, cmd_ready); miscompares++;
        end
        vectors++;
        if (mem_cmd_v !== 1'b0) begin
            $display("FAIL %s mem_cmd_v: got %b want 0", tag, mem_cmd_v); miscompares++;
        end
        vectors++;
        if (resp_v !== 1'b0) begin
            $display("FAIL %s resp_v: got %b want 0", tag, resp_v); miscompares++;
        end
    endtask

    // Issue everything in iss_q, checking order, moving it to pend_q.
    task automatic issue_n(input int n, input string tag);
        mem_cmd_ready = 1;
        for (int k = 0; k < n; k++) begin
            vectors++;
            if (mem_cmd_v !== 1'b1 || iss_q.size() == 0 || mem_cmd !== iss_q[0]) begin
                $display("FAIL %s issue%0d: got v=%b cmd=%h", tag, k, mem_cmd_v, mem_cmd);
                miscompares++;
            end
            if (iss_q.size() > 0) pend_q.push_back(iss_q.pop_front());
            tick();
        end
        mem_cmd_ready = 0;
    endtask

    task automatic accept_n(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            cmd_in = make_cmd(base + k);
            cmd_v = 1;
            iss_q.push_back(cmd_in);
            tick();
        end
        cmd_v = 0;
    endtask

    task automatic respond_pending();
        mem_resp = mem_model(pend_q.pop_front());
        mem_resp_v = 1;
        tick();
        mem_resp_v = 0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1;
        tick(); tick();
        reset = 0;
        check_idle_outputs("reset");
        tick();
    endtask

    task automatic test_fill_drain();
        bp_be_mmu_resp_s r;
        idle();
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (cmd_ready !== 1'b1) begin
                $display("FAIL fill_ready%0d: got %b want 1", i, cmd_ready); miscompares++;
            end
            cmd_in = make_cmd(i);
            cmd_v = 1;
            iss_q.push_back(cmd_in);
            tick();
            if (i == 0) begin
                vectors++;
                if (mem_cmd_v !== 1'b1) begin
                    $display("FAIL fill_first_issue_v: got %b want 1", mem_cmd_v); miscompares++;
                end
            end
        end
        cmd_v = 0;
        vectors++;
        if (cmd_ready !== 1'b0) begin
            $display("FAIL fill_full_ready: got %b want 0", cmd_ready); miscompares++;
        end
        issue_n(4, "fill");
        vectors++;
        if (mem_cmd_v !== 1'b0) begin
            $display("FAIL fill_issue_done: got %b want 0", mem_cmd_v); miscompares++;
        end
        pend_q.delete();
        for (int k = 0; k < 4; k++) begin
            vectors++;
            if (resp_v !== 1'b0) begin
                $display("FAIL fill_resp_early%0d: got %b want 0", k, resp_v); miscompares++;
            end
            r.exception = '0;
            r.data = 64'hA + 64'(k);
            mem_resp = r;
            mem_resp_v = 1;
            exp_q.push_back(r);
            tick();
            mem_resp_v = 0;
            vectors++;
            if (resp_v !== 1'b1 || resp_out !== exp_q[0]) begin
                $display("FAIL fill_resp%0d: got v=%b data=%h want data=%h", k, resp_v,
                         resp_out.data, exp_q[0].data);
                miscompares++;
            end
            void'(exp_q.pop_front());
            resp_yumi = 1;
            tick();
            resp_yumi = 0;
            if (k == 0) begin
                vectors++;
                if (cmd_ready !== 1'b1) begin
                    $display("FAIL fill_ready_after_yumi: got %b want 1", cmd_ready); miscompares++;
                end
            end
        end
    endtask

    task automatic test_exception();
        bp_be_mmu_resp_s r;
        idle();
        accept_n(100, 2);
        issue_n(2, "exc");
        pend_q.delete();
        r.exception = bp_be_mmu_exception_s'(8'h5A); r.data = 64'h1;
        mem_resp = r; mem_resp_v = 1; exp_q.push_back(r);
        tick();
        r.exception = '0; r.data = 64'h2;
        mem_resp = r; exp_q.push_back(r);
        tick();
        mem_resp_v = 0;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (resp_v !== 1'b1 || resp_out !== exp_q[0]) begin
                $display("FAIL exc_resp%0d: got v=%b exc=%h data=%h want exc=%h data=%h", k,
                         resp_v, resp_out.exception, resp_out.data, exp_q[0].exception,
                         exp_q[0].data);
                miscompares++;
            end
            void'(exp_q.pop_front());
            resp_yumi = 1;
            tick();
            resp_yumi = 0;
        end
        vectors++;
        if (resp_v !== 1'b0) begin
            $display("FAIL exc_empty: got %b want 0", resp_v); miscompares++;
        end
    endtask

    task automatic test_random();
        int sent = 0, recv = 0, cyc = 0;
        bit stalled = 0;
        bp_be_mmu_cmd_s last_cmd = '0;
        const int N = 1000;
        idle();
        iss_q.delete(); exp_q.delete(); pend_q.delete();
        while (recv < N && cyc < 20000) begin
            if (stalled) begin
                vectors++;
                if (mem_cmd_v !== 1'b1 || mem_cmd !== last_cmd) begin
                    $display("FAIL rand_stable: got v=%b cmd=%h want cmd=%h", mem_cmd_v,
                             mem_cmd, last_cmd);
                    miscompares++;
                end
            end
            mem_resp_v = 0;
            if (pend_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                mem_resp = mem_model(pend_q.pop_front());
                mem_resp_v = 1;
            end
            mem_cmd_ready = ($urandom_range(0, 3) != 0);
            if (mem_cmd_v && mem_cmd_ready) begin
                vectors++;
                if (iss_q.size() == 0 || mem_cmd !== iss_q[0]) begin
                    $display("FAIL rand_issue: got cmd=%h", mem_cmd); miscompares++;
                end
                if (iss_q.size() > 0) pend_q.push_back(iss_q.pop_front());
            end
            stalled = mem_cmd_v && !mem_cmd_ready;
            last_cmd = mem_cmd;
            cmd_v = 0;
            if (sent < N && $urandom_range(0, 3) != 0) begin
                cmd_in = make_cmd(1000 + sent);
                cmd_v = 1;
                if (cmd_ready) begin
                    iss_q.push_back(cmd_in);
                    exp_q.push_back(mem_model(cmd_in));
                    sent++;
                end
            end
            resp_yumi = 0;
            if (resp_v && $urandom_range(0, 2) != 0) begin
                resp_yumi = 1;
                vectors++;
                if (exp_q.size() == 0 || resp_out !== exp_q[0]) begin
                    $display("FAIL rand_resp%0d: got %h", recv, resp_out); miscompares++;
                end
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                recv++;
            end
            tick();
            cyc++;
        end
        idle();
        vectors++;
        if (recv != N) begin
            $display("FAIL rand_timeout: got %0d responses want %0d", recv, N); miscompares++;
        end
        iss_q.delete(); exp_q.delete(); pend_q.delete();
    endtask

    task automatic test_flush_drop();
        bp_be_mmu_cmd_s nc;
        idle();
        accept_n(200, 3);
        issue_n(3, "fd");
        respond_pending();
        vectors++;
        if (resp_v !== 1'b1) begin
            $display("FAIL fd_pre_flush_resp_v: got %b want 1", resp_v); miscompares++;
        end
        flush = 1;
        tick();
        flush = 0;
        vectors++;
        if (dut.drop_cnt_r !== 3'd2) begin
            $display("FAIL fd_drop_cnt: got %0d want 2", dut.drop_cnt_r); miscompares++;
        end
        check_idle_outputs("fd_post_flush");
        nc = make_cmd(203);
        cmd_in = nc; cmd_v = 1; mem_cmd_ready = 1;
        tick();
        cmd_v = 0;
        vectors++;
        if (mem_cmd_v !== 1'b0) begin
            $display("FAIL fd_blocked0: got %b want 0", mem_cmd_v); miscompares++;
        end
        respond_pending();
        vectors++;
        if (mem_cmd_v !== 1'b0 || resp_v !== 1'b0) begin
            $display("FAIL fd_blocked1: got v=%b rv=%b want 0 0", mem_cmd_v, resp_v);
            miscompares++;
        end
        respond_pending();
        vectors++;
        if (mem_cmd_v !== 1'b1 || mem_cmd !== nc || resp_v !== 1'b0) begin
            $display("FAIL fd_issue_after_drop: got v=%b cmd=%h rv=%b", mem_cmd_v, mem_cmd,
                     resp_v);
            miscompares++;
        end
        tick();
        mem_cmd_ready = 0;
        exp_q.push_back(mem_model(nc));
        pend_q.push_back(nc);
        respond_pending();
        vectors++;
        if (resp_v !== 1'b1 || resp_out !== exp_q[0]) begin
            $display("FAIL fd_new_resp: got v=%b data=%h want data=%h", resp_v,
                     resp_out.data, exp_q[0].data);
            miscompares++;
        end
        void'(exp_q.pop_front());
        resp_yumi = 1;
        tick();
        resp_yumi = 0;
    endtask

    task automatic test_flush_same();
        idle();
        accept_n(300, 3);
        issue_n(2, "fs");
        cmd_in = make_cmd(303); cmd_v = 1;
        mem_cmd_ready = 1;
        mem_resp = mem_model(pend_q.pop_front()); mem_resp_v = 1;
        flush = 1;
        tick();
        idle();
        vectors++;
        if (dut.drop_cnt_r !== 3'd2) begin
            $display("FAIL fs_drop_cnt: got %0d want 2", dut.drop_cnt_r); miscompares++;
        end
        check_idle_outputs("fs_post_flush");
        pend_q.push_back(iss_q.pop_front());
        for (int k = 0; k < 2; k++) begin
            respond_pending();
            vectors++;
            if (mem_cmd_v !== 1'b0 || resp_v !== 1'b0) begin
                $display("FAIL fs_drain%0d: got v=%b rv=%b want 0 0", k, mem_cmd_v, resp_v);
                miscompares++;
            end
        end
        vectors++;
        if (dut.drop_cnt_r !== 3'd0) begin
            $display("FAIL fs_drop_zero: got %0d want 0", dut.drop_cnt_r); miscompares++;
        end
        iss_q.delete(); pend_q.delete();
    endtask

    task automatic test_reset_mid();
        idle();
        accept_n(400, 3);
        issue_n(2, "rm");
        respond_pending();
        vectors++;
        if (resp_v !== 1'b1) begin
            $display("FAIL rm_pre_reset_resp_v: got %b want 1", resp_v); miscompares++;
        end
        reset = 1;
        tick();
        reset = 0;
        check_idle_outputs("rm_post_reset");
        vectors++;
        if (dut.drop_cnt_r !== 3'd0) begin
            $display("FAIL rm_drop_cnt: got %0d want 0", dut.drop_cnt_r); miscompares++;
        end
        tick();
        iss_q.delete(); pend_q.delete(); exp_q.delete();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_exception();
        test_random();
        test_flush_drop();
        test_flush_same();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
